hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : Issue-stage request, operand checks and hazard status bundle.
// Revision : 1.0
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int LAT_W    = 4
);
    localparam int c_ADDR_W = $clog2(NUM_REGS);

    logic                               iss_valid_i;
    logic                               iss_wr_en_i;
    logic [c_ADDR_W-1:0]                iss_rd_i;
    logic [LAT_W-1:0]                   iss_lat_i;
    logic [NUM_SRC-1:0]                 src_valid_i;
    logic [NUM_SRC-1:0][c_ADDR_W-1:0]   src_addr_i;
    logic                               flush_i;
    logic [NUM_SRC-1:0]                 src_busy_o;
    logic [NUM_SRC-1:0]                 src_fwd_o;
    logic                               stall_o;
    logic                               iss_accept_o;
    logic [c_ADDR_W:0]                  pending_o;

    modport master (
        output iss_valid_i, iss_wr_en_i, iss_rd_i, iss_lat_i,
               src_valid_i, src_addr_i, flush_i,
        input  src_busy_o, src_fwd_o, stall_o, iss_accept_o, pending_o
    );

    modport slave (
        input  iss_valid_i, iss_wr_en_i, iss_rd_i, iss_lat_i,
               src_valid_i, src_addr_i, flush_i,
        output src_busy_o, src_fwd_o, stall_o, iss_accept_o, pending_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register latency countdown scoreboard for RAW/WAW issue gating.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int LAT_W    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int c_ADDR_W = $clog2(NUM_REGS);
    localparam int c_PEND_W = c_ADDR_W + 1;

    logic [LAT_W-1:0]    r_cnt     [1:NUM_REGS-1];
    logic [LAT_W-1:0]    w_cnt_nxt [1:NUM_REGS-1];
    logic [LAT_W-1:0]    w_cnt     [NUM_REGS];
    logic [c_PEND_W-1:0] r_pending;
    logic [c_PEND_W-1:0] w_pending_nxt;
    logic [LAT_W-1:0]    w_lat_eff;
    logic [NUM_SRC-1:0]  w_busy;
    logic [NUM_SRC-1:0]  w_fwd;
    logic                w_waw;
    logic                w_stall;
    logic                w_accept;
    logic                w_load;

    // x0 is viewed as permanently ready so every lookup can index uniformly
    always_comb begin
        w_cnt[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_cnt[r] = r_cnt[r];
        end
    end

    assign w_lat_eff = (bus.iss_lat_i == '0) ? LAT_W'(1) : bus.iss_lat_i;

    always_comb begin
        w_busy = '0;
        w_fwd  = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            w_fwd[p]  = bus.src_valid_i[p] && (w_cnt[bus.src_addr_i[p]] == LAT_W'(1));
            w_busy[p] = bus.src_valid_i[p] && (w_cnt[bus.src_addr_i[p]] >= LAT_W'(2));
        end
    end

    // A new write must not retire before an older write to the same register
    assign w_waw    = bus.iss_wr_en_i && (bus.iss_rd_i != '0)
                      && (w_cnt[bus.iss_rd_i] >= w_lat_eff);
    assign w_stall  = bus.iss_valid_i && ((|w_busy) || w_waw);
    assign w_accept = bus.iss_valid_i && !w_stall;
    assign w_load   = w_accept && bus.iss_wr_en_i && (bus.iss_rd_i != '0);

    always_comb begin
        w_pending_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.flush_i) begin
                w_cnt_nxt[r] = '0;
            end else if (w_load && (bus.iss_rd_i == c_ADDR_W'(r))) begin
                w_cnt_nxt[r] = w_lat_eff;
            end else if (r_cnt[r] != '0) begin
                w_cnt_nxt[r] = r_cnt[r] - LAT_W'(1);
            end else begin
                w_cnt_nxt[r] = '0;
            end
            if (w_cnt_nxt[r] != '0) begin
                w_pending_nxt = w_pending_nxt + c_PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.src_busy_o   = w_busy;
    assign bus.src_fwd_o    = w_fwd;
    assign bus.stall_o      = w_stall;
    assign bus.iss_accept_o = w_accept;
    assign bus.pending_o    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed scoreboard bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;
    localparam int NUM_REGS = 32;
    localparam int NUM_SRC  = 2;
    localparam int LAT_W    = 4;

    localparam int K_BUSY = 0;
    localparam int K_FWD  = 1;
    localparam int K_STALL = 2;
    localparam int K_ACC  = 3;
    localparam int K_PEND = 4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] step;
        logic [7:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   step = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) bus ();

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] observed(input logic [2:0] k);
        case (k)
            3'd0:    observed = 8'(bus.src_busy_o);
            3'd1:    observed = 8'(bus.src_fwd_o);
            3'd2:    observed = 8'(bus.stall_o);
            3'd3:    observed = 8'(bus.iss_accept_o);
            default: observed = 8'(bus.pending_o);
        endcase
    endfunction

    function automatic string kind_name(input logic [2:0] k);
        case (k)
            3'd0:    kind_name = "busy";
            3'd1:    kind_name = "fwd";
            3'd2:    kind_name = "stall";
            3'd3:    kind_name = "accept";
            default: kind_name = "pending";
        endcase
    endfunction

    task automatic drive(input logic v, input logic wr, input int rd, input int lat,
                         input logic [1:0] sv, input int a0, input int a1, input logic fl);
        bus.iss_valid_i   = v;
        bus.iss_wr_en_i   = wr;
        bus.iss_rd_i      = 5'(rd);
        bus.iss_lat_i     = 4'(lat);
        bus.src_valid_i   = sv;
        bus.src_addr_i[0] = 5'(a0);
        bus.src_addr_i[1] = 5'(a1);
        bus.flush_i       = fl;
        #1;
    endtask

    task automatic expect_out(input int k, input int v);
        sb_q.push_back('{kind: 3'(k), step: 8'(step), exp: 8'(v)});
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observed(e.kind);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL step%0d %s observed=%0h expected=%0h",
                       e.step, kind_name(e.kind), obs, e.exp);
            end
        end
    endtask

    task automatic comb(input int busy, input int fwd, input int stall, input int acc);
        step++;
        expect_out(K_BUSY, busy);
        expect_out(K_FWD, fwd);
        expect_out(K_STALL, stall);
        expect_out(K_ACC, acc);
        drain();
    endtask

    task automatic tick_pend(input int p);
        @(posedge clk);
        #1;
        expect_out(K_PEND, p);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset overrides an issue presented during reset
        drive(1'b1, 1'b1, 5, 3, 2'b01, 5, 0, 1'b0);
        tick_pend(0);
        tick_pend(0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 2'b11, 5, 7, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(0);

        // RAW: rd=5 lat=3, then reader of x5 each cycle
        drive(1'b1, 1'b1, 5, 3, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        drive(1'b1, 1'b0, 0, 0, 2'b01, 5, 0, 1'b0);
        comb(1, 0, 1, 0);
        tick_pend(1);
        comb(1, 0, 1, 0);
        tick_pend(1);
        comb(0, 1, 0, 1);
        tick_pend(0);
        comb(0, 0, 0, 1);
        tick_pend(0);

        // x0 is never tracked
        drive(1'b1, 1'b1, 0, 7, 2'b11, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(0);
        drive(1'b1, 1'b0, 0, 0, 2'b11, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(0);

        // WAW against cnt[8]=4
        drive(1'b1, 1'b1, 8, 4, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        drive(1'b1, 1'b1, 8, 2, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 1, 0);
        tick_pend(1);
        drive(1'b1, 1'b1, 8, 5, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        // cnt[8]==5 now: equal latency still stalls, then count down to forwarding
        drive(1'b1, 1'b1, 8, 5, 2'b01, 8, 0, 1'b0);
        comb(1, 0, 1, 0);
        tick_pend(1);
        drive(1'b0, 1'b0, 0, 0, 2'b01, 8, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            comb(1, 0, 0, 0);
            tick_pend(1);
        end
        comb(0, 1, 0, 0);
        tick_pend(0);

        // Dual-port mixed: cnt[3]=1, cnt[4]=2
        drive(1'b1, 1'b1, 4, 3, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        drive(1'b1, 1'b1, 3, 1, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(2);
        drive(1'b1, 1'b0, 0, 0, 2'b11, 3, 4, 1'b0);
        comb(2, 1, 1, 0);
        tick_pend(1);
        comb(0, 2, 0, 1);
        tick_pend(0);

        // Flush beats a same-cycle accepted issue
        drive(1'b1, 1'b1, 9, 7, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        drive(1'b1, 1'b1, 10, 2, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(2);
        drive(1'b1, 1'b1, 11, 4, 2'b00, 0, 0, 1'b1);
        comb(0, 0, 0, 1);
        tick_pend(0);
        drive(1'b0, 1'b0, 0, 0, 2'b11, 9, 11, 1'b0);
        comb(0, 0, 0, 0);
        tick_pend(0);
        drive(1'b0, 1'b0, 0, 0, 2'b01, 10, 0, 1'b0);
        comb(0, 0, 0, 0);
        tick_pend(0);

        // Reset mid-countdown, then lat=0 treated as 1
        drive(1'b1, 1'b1, 12, 9, 2'b00, 0, 0, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 14, 5, 2'b00, 0, 0, 1'b1);
        tick_pend(0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 13, 0, 2'b11, 12, 14, 1'b0);
        comb(0, 0, 0, 1);
        tick_pend(1);
        drive(1'b0, 1'b0, 0, 0, 2'b01, 13, 0, 1'b0);
        comb(0, 1, 0, 0);
        tick_pend(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
